// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce/sync/edge block.
// State encoding and synchronizer depth bounds.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 4;

endpackage

// File: rtl/debounce_sync_edge_sync_chain.sv
// Multi-flop synchronizer for an asynchronous input.
// Shift register of SYNC_STAGES flops, synchronous active-low reset.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad
    $error("sync_chain: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] ff;

  // shift din through the chain every cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      ff <= {SYNC_STAGES{INIT}};
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], din};
    end
  end

  assign s = ff[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync_edge.sv
// Debounce + synchronize + edge-detect front end for flop inputs.
// Build option: DEBOUNCE_TOGGLE_EN adds the push-on/push-off tog output.
module debounce_sync_edge
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STABLE_CNT  = 50000,
  parameter logic        INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic ce,
  output logic q,
  output logic rise,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic fall,
  output logic tog
`else
  output logic fall
`endif
);

  if (STABLE_CNT < 2 || STABLE_CNT > (2**CNT_W) - 1) begin : g_bad
    $error("debounce_sync_edge: STABLE_CNT out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .INIT       (INIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .din(din),
    .s  (s)
  );

  // stability FSM: accept a new level after STABLE_CNT qualified samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT ? IDLE_HIGH : IDLE_LOW;
      cnt   <= '0;
      q     <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (ce) begin
        unique case (state)
          IDLE_LOW: begin
            if (s) begin
              state <= WAIT_HIGH;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_HIGH: begin
            if (!s) begin
              state <= IDLE_LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE_HIGH;
              q     <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!s) begin
              state <= WAIT_LOW;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_LOW: begin
            if (s) begin
              state <= IDLE_HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE_LOW;
              q     <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic rise_hit;

  assign rise_hit = ce && s && (state == WAIT_HIGH)
                 && (cnt == CNT_LAST);

  // flip tog on the same edge that raises rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      tog <= 1'b0;
    end else if (rise_hit) begin
      tog <= ~tog;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_sync_edge.sv
// Scoreboard bench for debounce_sync_edge.
// Reference model pushes per-edge expectations; compared after each edge.
module tb_debounce_sync_edge;

  localparam int SYNC = 2;
  localparam int STAB = 4;

  logic clk = 1'b0;
  logic rst, din, ce;
  logic q, rise, fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic tog;
`endif

  always #5 clk = ~clk;

  debounce_sync_edge #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (16),
    .STABLE_CNT (STAB),
    .INIT       (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .ce  (ce),
    .q   (q),
    .rise(rise),
`ifdef DEBOUNCE_TOGGLE_EN
    .fall(fall),
    .tog (tog)
`else
    .fall(fall)
`endif
  );

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic tog;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int rise_edge, fall_edge;
  int n_rise = 0;

  logic [SYNC-1:0] msync;
  logic mq, mrise, mfall, mtog;
  int   mrun;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input logic r, input logic d,
                            input logic e);
    logic so;
    if (!r) begin
      msync = '0;
      mq = 1'b0;
      mrise = 1'b0;
      mfall = 1'b0;
      mtog = 1'b0;
      mrun = 0;
    end else begin
      so = msync[SYNC-1];
      msync = {msync[SYNC-2:0], d};
      mrise = 1'b0;
      mfall = 1'b0;
      if (e) begin
        if (so != mq) begin
          mrun++;
          if (mrun == STAB) begin
            mq = so;
            mrise = so;
            mfall = ~so;
            mrun = 0;
            if (so) mtog = ~mtog;
          end
        end else begin
          mrun = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic d,
                      input logic e);
    exp_t x;
    rst = r;
    din = d;
    ce = e;
    model_edge(r, d, e);
    sb.push_back('{mq, mrise, mfall, mtog});
    @(posedge clk);
    #1;
    edge_n++;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("q", q, x.q);
      chk("rise", rise, x.rise);
      chk("fall", fall, x.fall);
      chk("excl", rise & fall, 0);
      chk("rise_ce", rise & ~e, 0);
`ifdef DEBOUNCE_TOGGLE_EN
      chk("tog", tog, x.tog);
`endif
    end
    if (rise) begin
      n_rise++;
      if (rise_edge < 0) rise_edge = edge_n;
    end
    if (fall && fall_edge < 0) fall_edge = edge_n;
  endtask

  initial begin
    int e0;
    rst = 1'b0;
    din = 1'b0;
    ce = 1'b1;
    #2;

    // reset, then clean rising step
    step(0, 1, 1);
    step(0, 1, 1);
    chk("rst_q", q, 0);
    chk("rst_rise", rise, 0);
    step(1, 0, 1);
    chk("post_rst_rise", rise, 0);
    step(1, 0, 1);
    e0 = edge_n;
    rise_edge = -1;
    fall_edge = -1;
    repeat (10) step(1, 1, 1);
    chk("step_rise_lat", rise_edge - e0, SYNC + STAB);
    chk("step_no_fall", fall_edge, -1);

    // falling step
    e0 = edge_n;
    rise_edge = -1;
    fall_edge = -1;
    repeat (10) step(1, 0, 1);
    chk("fall_lat", fall_edge - e0, SYNC + STAB);
    chk("fall_no_rise", rise_edge, -1);

    // bounce: 1,1,1,0 then steady 1
    e0 = edge_n;
    rise_edge = -1;
    fall_edge = -1;
    repeat (3) step(1, 1, 1);
    step(1, 0, 1);
    repeat (10) step(1, 1, 1);
    chk("bounce_lat", rise_edge - e0, 10);
    chk("bounce_no_fall", fall_edge, -1);

    // back low, then ce every third cycle
    repeat (10) step(1, 0, 1);
    e0 = edge_n;
    rise_edge = -1;
    for (int i = 0; i < 24; i++) step(1, 1, (i % 3) == 0);
    chk("ce_rose", q, 1);
    chk("ce_lat_gt", rise_edge - e0 > SYNC + STAB, 1);
    repeat (10) step(1, 0, 1);

    // reset while in WAIT_HIGH with cnt=2
    repeat (4) step(1, 1, 1);
    rise_edge = -1;
    step(0, 1, 1);
    chk("midrst_q", q, 0);
    e0 = edge_n;
    repeat (10) step(1, 1, 1);
    chk("midrst_lat", rise_edge - e0, SYNC + STAB);

    // two more full toggles for tog
    repeat (2) begin
      repeat (10) step(1, 0, 1);
      repeat (10) step(1, 1, 1);
    end
    repeat (10) step(1, 0, 1);

    // random bursty input with random ce
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 5) ? (($urandom_range(0, 3) == 0) ? ~din : din) : din,
           ($urandom_range(0, 3) != 0));
    end
    chk("sb_drained", sb.size(), 0);
    chk("some_rises", n_rise > 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
